tri_bus_port: RTL
=================

TRI_BUS_PORT -- requirements
Module: tri_bus_port

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of the shared bus and data paths.
REQ-002 SHALL have parameter TURN_CYC, default 1, number of bus-release (all-Z) cycles after a drive burst; legal range 1..15.
REQ-003 SHALL have parameter CNT_W, default 16, width of the transfer counter.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 data_to_from_bus  inout  WIDTH  shared tri-state bus.
REQ-007 bus_grant  input  1  external arbiter permits this port to drive.
REQ-008 tx_valid  input  1  tx_data holds a word to send.
REQ-009 tx_data  input  WIDTH  word to send.
REQ-010 tx_ready  output  1  port accepts tx_data this cycle.
REQ-011 rcv_data  input  1  sample the bus this cycle.
REQ-012 rx_valid  output  1  one-cycle pulse; rx_data updated.
REQ-013 rx_data  output  WIDTH  last captured bus word.
REQ-014 drive_active  output  1  port currently drives the bus.
REQ-015 tx_cnt  output  CNT_W  count of accepted tx words.

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE, TURN.
REQ-017 SHALL drive data_to_from_bus from an internal WIDTH-bit output register only while state = DRIVE, else all bits 'z'.
REQ-018 SHALL assert drive_active exactly when state = DRIVE.
REQ-019 tx_ready SHALL be combinational: 1 iff bus_grant = 1 and state is IDLE or DRIVE.
REQ-020 SHALL accept a word on a rising edge where tx_valid and tx_ready are both 1; the output register loads tx_data, tx_cnt increments by 1.
REQ-021 IDLE -> DRIVE on an accept; first word appears on the bus in the cycle after the accept edge (latency 1).
REQ-022 DRIVE -> DRIVE on an accept (back-to-back burst, one word per cycle, no gap).
REQ-023 DRIVE -> TURN when no accept occurs (tx_valid = 0 or bus_grant = 0); bus goes Z in the cycle after that edge.
REQ-024 TURN SHALL last exactly TURN_CYC cycles via a down-counter, then -> IDLE; tx_ready = 0 throughout TURN regardless of bus_grant.
REQ-025 tx_data changes while tx_ready = 0 SHALL have no effect; tx_valid may be held high indefinitely.
REQ-026 SHALL capture data_to_from_bus into rx_data on a rising edge where rcv_data = 1 and state is IDLE or TURN; rx_valid = 1 for the following cycle only.
REQ-027 rcv_data = 1 while state = DRIVE SHALL be ignored (no self-capture, rx_valid stays 0).
REQ-028 rx_data SHALL hold its value between captures.
REQ-029 tx_cnt SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-030 An accept and a rcv_data request on the same edge from IDLE: accept wins, no capture.

Reset
REQ-031 On rst = 1, immediately (without clock): state = IDLE, bus all 'z', drive_active = 0, rx_valid = 0, rx_data = 0, tx_cnt = 0, output register = 0, TURN counter = 0.
REQ-032 rst asserted during DRIVE or TURN SHALL abandon the burst; no TURN period is inserted after deassertion.
REQ-033 First accept possible on the first rising edge after rst deasserts.

Verification
REQ-034 Reset: rst pulse mid-DRIVE with bus = 0xDEADBEEF -> bus Z and drive_active = 0 before next clk edge; tx_cnt = 0.
REQ-035 Single word: bus_grant = 1, tx_valid one cycle with 0x12345678 -> bus = 0x12345678 for 1 cycle, then Z for TURN_CYC cycles, then IDLE; tx_cnt = 1.
REQ-036 Burst: 4 consecutive accepts 0x1,0x2,0x3,0x4 -> bus shows them on 4 consecutive cycles, no Z gap; tx_cnt = 4.
REQ-037 Grant loss: bus_grant drops after word 2 of a 4-word burst -> TURN, tx_ready = 0 for TURN_CYC cycles, words 3/4 accepted after return to IDLE with grant restored.
REQ-038 Receive: external driver puts 0xA5A5A5A5 on bus, rcv_data = 1 in IDLE -> rx_valid one cycle, rx_data = 0xA5A5A5A5; rcv_data during DRIVE -> no rx_valid.
REQ-039 Wrap: CNT_W = 4, 17 accepts -> tx_cnt = 1.

Source files
------------

// File: rtl/tri_bus_port_if.sv
// tri_bus_port_if: handshake/status bundle of tri_bus_port; master = bus user, slave = port. WIDTH/CNT_W must match the port's.
interface tri_bus_port_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             bus_grant;
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  logic             rcv_data;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             drive_active;
  logic [CNT_W-1:0] tx_cnt;
  modport master (
    output bus_grant, tx_valid, tx_data, rcv_data,
    input  tx_ready, rx_valid, rx_data, drive_active, tx_cnt
  );
  modport slave (
    input  bus_grant, tx_valid, tx_data, rcv_data,
    output tx_ready, rx_valid, rx_data, drive_active, tx_cnt
  );
endinterface

// File: rtl/tri_bus_port.sv
// tri_bus_port: tri-state bus port; clk/rst, inout data_to_from_bus, p = handshake bundle (tx in, rx out, drive_active, tx_cnt).
module tri_bus_port #(
  parameter int WIDTH    = 32,
  parameter int TURN_CYC = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] data_to_from_bus,
  tri_bus_port_if.slave    p
);
  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] out_reg;
  logic [3:0]       turn_cnt;
  logic             accept, capture;
  assign p.tx_ready       = p.bus_grant && state != TURN;
  assign accept           = p.tx_valid && p.tx_ready;
  // an accept from IDLE suppresses a same-edge capture
  assign capture          = p.rcv_data && state != DRIVE && !accept;
  assign p.drive_active   = state == DRIVE;
  assign data_to_from_bus = p.drive_active ? out_reg : {WIDTH{1'bz}};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    state_n = accept ? DRIVE :
              state == DRIVE ? TURN :
              (state == TURN && turn_cnt == 4'd1) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_reg     <= '0;
      turn_cnt    <= '0;
      p.tx_cnt    <= '0;
      p.rx_valid  <= 1'b0;
      p.rx_data   <= '0;
    end else begin
      if (accept) begin
        out_reg  <= p.tx_data;
        p.tx_cnt <= p.tx_cnt + CNT_W'(1);
      end
      turn_cnt   <= (state == DRIVE && !accept) ? 4'(TURN_CYC) :
                    state == TURN ? turn_cnt - 4'd1 : turn_cnt;
      p.rx_valid <= capture;
      if (capture) p.rx_data <= data_to_from_bus;
    end
endmodule
